// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl
// Shared-access controller for an external FIFO. Up to N_REQ producers are
// arbitrated round-robin onto the FIFO write port. FIFO reads are sequenced,
// one at a time, into a registered valid/ready output stage. An internal
// occupancy credit count keeps the FIFO from being written when full or read
// when empty.
//
// Optional build macro FIFO_SHARE_CHECK_EN: when defined, err is a sticky flag
// raised by a write into a full FIFO or a read from an empty one. When it is
// undefined, err is tied low and fifo_full / fifo_empty are ignored.
//
// Read FSM states
//   state   | meaning
//   R_IDLE  | no read in flight; start one when occ > 0
//   R_ISSUE | fifo_rd_en high for this single cycle
//   R_WAIT  | FIFO presents data; captured into out_data at end of cycle
//   R_HOLD  | out_valid high, out_data stable until out_ready
module fifo_share_ctrl #(
    parameter int N_REQ = 4,
    parameter int DW    = 2,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   req_data,
    output logic [N_REQ-1:0]      gnt,
    output logic                  fifo_wr_en,
    output logic [DW-1:0]         fifo_din,
    output logic                  fifo_rd_en,
    input  logic [DW-1:0]         fifo_dout,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    input  logic                  out_ready,
    output logic                  err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_WAIT,
        R_HOLD
    } rstate_t;

    rstate_t          rstate;
    logic [PW-1:0]    rr_ptr;
    logic [OW-1:0]    occ;
    logic [N_REQ-1:0] elig;
    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [N_REQ-1:0] win_gnt;
    logic [DW-1:0]    win_data;
    logic             wr_issue;
    logic             rd_issue;

    // The producer currently shown gnt sits out one arbitration round.
    assign elig = req & ~gnt;

    // Round-robin search: first eligible index at or above the pointer,
    // otherwise wrap to the first eligible index from zero.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_gnt   = '0;
        win_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && elig[i] && (PW'(i) >= rr_ptr)) begin
                win_found  = 1'b1;
                win_idx    = PW'(i);
                win_gnt    = '0;
                win_gnt[i] = 1'b1;
                win_data   = req_data[i*DW +: DW];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && elig[i]) begin
                win_found  = 1'b1;
                win_idx    = PW'(i);
                win_gnt    = '0;
                win_gnt[i] = 1'b1;
                win_data   = req_data[i*DW +: DW];
            end
        end
    end

    // Credits are taken when a transfer is issued, not when the FIFO sees it,
    // so a write still in flight already counts against the depth.
    assign wr_issue = win_found && (occ < OW'(DEPTH));
    assign rd_issue = (rstate == R_IDLE) && (occ != '0);

    // Write side: register the grant, write strobe and data of the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt        <= '0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            rr_ptr     <= '0;
        end else if (wr_issue) begin
            gnt        <= win_gnt;
            fifo_wr_en <= 1'b1;
            fifo_din   <= win_data;
            rr_ptr     <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end else begin
            gnt        <= '0;
            fifo_wr_en <= 1'b0;
        end
    end

    // Occupancy credit count; a simultaneous write and read cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({wr_issue, rd_issue})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Read sequencer: one read in flight, drained through the output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate     <= R_IDLE;
            fifo_rd_en <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (rd_issue) begin
                        rstate     <= R_ISSUE;
                        fifo_rd_en <= 1'b1;
                    end
                end
                R_ISSUE: begin
                    rstate     <= R_WAIT;
                    fifo_rd_en <= 1'b0;
                end
                R_WAIT: begin
                    out_data  <= fifo_dout;
                    out_valid <= 1'b1;
                    rstate    <= R_HOLD;
                end
                R_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rstate    <= R_IDLE;
                    end
                end
                default: begin
                    rstate     <= R_IDLE;
                    fifo_rd_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_SHARE_CHECK_EN
    // Sticky protocol error: write into a full FIFO or read from an empty one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((fifo_wr_en && fifo_full) || (fifo_rd_en && fifo_empty)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_flags;

    // Checker compiled out: flags are ignored and err never rises.
    always_comb begin
        unused_flags = fifo_full ^ fifo_empty;
        err          = 1'b0;
    end
`endif

endmodule
